// File: rtl/c_prbs_checker_if.sv
// Stream and status bundle between a PRBS source and c_prbs_checker.
// The source side drives the stream; the checker side returns status.
interface c_prbs_checker_if #(
    parameter int width = 32,
    parameter int cnt_width = 16
);
    logic active;
    logic valid;
    logic clear;
    logic [0:width-1] feedback;
    logic [0:width-1] d;
    logic locked;
    logic error;
    logic sticky_err;
    logic [0:cnt_width-1] err_count;

    modport master (
        output active, valid, clear, feedback, d,
        input  locked, error, sticky_err, err_count
    );

    modport slave (
        input  active, valid, clear, feedback, d,
        output locked, error, sticky_err, err_count
    );
endinterface

// File: rtl/c_prbs_checker.sv
// Self-synchronising LFSR pattern checker with lock tracking and error count.
// Define C_PRBS_CHECKER_BITERR_EN to count mismatching bits instead of words.
module c_prbs_checker #(
    parameter int width = 32,
    parameter int lock_count = 4,
    parameter int loss_count = 4,
    parameter int cnt_width = 16
) (
    input logic clk,
    input logic reset,
    c_prbs_checker_if.slave bus
);
    localparam int mw = $clog2(lock_count + 1);
    localparam int xw = $clog2(loss_count + 1);
    localparam int pw = $clog2(width + 1);
    localparam int sw = ((cnt_width > pw) ? cnt_width : pw) + 1;
    localparam logic [0:0] HUNT = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0] st_q;
    logic [0:width-1] lfsr_q;
    logic [0:width-1] pred;
    logic [mw-1:0] match_q;
    logic [xw-1:0] miss_q;
    logic err_q;
    logic sticky_q;
    logic [cnt_width-1:0] cnt_q;
    logic [cnt_width-1:0] cnt_sat;
    logic [pw-1:0] inc;
    logic [sw-1:0] sum;
    logic zero;
    logic hit;
    logic unused_fb;

    assign unused_fb = bus.feedback[0];

    always_comb begin
        pred = '0;
        pred[0] = lfsr_q[width-1];
        for (int i = 1; i < width; i++) begin
            pred[i] = lfsr_q[i-1] ^ (bus.feedback[i] & lfsr_q[width-1]);
        end
    end

    assign zero = (bus.d == '0);
    assign hit = !zero && (bus.d == pred);

`ifdef C_PRBS_CHECKER_BITERR_EN
    assign inc = pw'($countones(bus.d ^ pred));
`else
    assign inc = pw'(1);
`endif

    // Widened add so the saturation test cannot wrap.
    assign sum = sw'(cnt_q) + sw'(inc);
    assign cnt_sat = (sum > sw'({cnt_width{1'b1}})) ?
                     {cnt_width{1'b1}} : sum[cnt_width-1:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q <= HUNT;
            lfsr_q <= '1;
            match_q <= '0;
            miss_q <= '0;
            err_q <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            err_q <= 1'b0;
            if (bus.active && bus.valid) begin
                if (st_q == HUNT) begin
                    unique case (1'b1)
                        zero: match_q <= '0;
                        hit: begin
                            lfsr_q <= bus.d;
                            match_q <= match_q + 1'b1;
                            if (match_q == mw'(lock_count - 1)) begin
                                st_q <= LOCKED;
                                miss_q <= '0;
                            end
                        end
                        default: begin
                            lfsr_q <= bus.d;
                            match_q <= '0;
                        end
                    endcase
                end else begin
                    lfsr_q <= pred;
                    if (hit) begin
                        miss_q <= '0;
                    end else begin
                        err_q <= 1'b1;
                        sticky_q <= 1'b1;
                        cnt_q <= cnt_sat;
                        if (miss_q == xw'(loss_count - 1)) begin
                            st_q <= HUNT;
                            match_q <= '0;
                            miss_q <= '0;
                        end else begin
                            miss_q <= miss_q + 1'b1;
                        end
                    end
                end
            end
            if (bus.active && bus.clear) begin
                cnt_q <= '0;
                sticky_q <= 1'b0;
            end
        end
    end

    assign bus.locked = (st_q == LOCKED);
    assign bus.error = err_q;
    assign bus.sticky_err = sticky_q;
    assign bus.err_count = cnt_q;
endmodule
